pingpong_mc_ram: RTL and testbench

- Parametrised successor to the single-channel ping-pong sample RAM.
- Captures interleaved multi-channel audio samples (e.g. I2S L/R) into two banks of DEPTH frames each.
- Hands a full bank to a downstream consumer (VU meter, filter) with the buffer_ready / read_enable / read_ack handshake.
- Adds channel tagging, channel-alignment checking, configurable overrun policy and overrun statistics.

---
 rtl/pingpong_pkg.sv | 24 ++
 rtl/pingpong_mc_wr_ctrl.sv | 129 ++++++++++++
 rtl/pingpong_mc_ram.sv | 177 +++++++++++++++++
 tb/tb_pingpong_mc_ram.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/pingpong_pkg.sv
// -----------------------------------------------------------------------------
// pingpong_pkg
// Shared types and helpers for the multi-channel ping-pong sample RAM:
//   ovr_mode_e  - overrun policy (drop the new bank / overwrite the reader)
//   rd_state_e  - read-side state
//   idx_width() - index width for a count of n items, never less than 1 bit
// -----------------------------------------------------------------------------
package pingpong_pkg;

  typedef enum logic {
    OVR_DROP      = 1'b0,
    OVR_OVERWRITE = 1'b1
  } ovr_mode_e;

  typedef enum logic {
    RD_IDLE   = 1'b0,
    RD_ACTIVE = 1'b1
  } rd_state_e;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage : pingpong_pkg

// File: rtl/pingpong_mc_wr_ctrl.sv
// -----------------------------------------------------------------------------
// pingpong_mc_wr_ctrl
// Write side of the ping-pong RAM: channel alignment check, write index and
// bank select, bank-full handling (swap or overrun) and overrun statistics.
//
// Ports:
//   clk_i, rst_ni     clock, asynchronous active-low reset
//   sample_ready_i    strobe: a sample is offered this cycle
//   sample_ch_i       channel tag of the offered sample
//   rd_busy_i         reader currently holds unread words
//   rd_final_ack_i    reader acks its final word this cycle
//   wr_en_o           store the offered sample at (wr_bank_o, wr_idx_o)
//   wr_bank_o         bank being filled
//   wr_idx_o          word index within that bank
//   swap_o            hand wr_bank_o to the reader this cycle
//   overrun_o         one-cycle pulse after an overrun
//   overrun_cnt_o     saturating overrun count
//   sync_err_o        sticky channel misalignment flag
// -----------------------------------------------------------------------------
module pingpong_mc_wr_ctrl
  import pingpong_pkg::*;
#(
  parameter int        DEPTH    = 256,
  parameter int        NUM_CH   = 2,
  parameter ovr_mode_e OVR_MODE = OVR_DROP,
  parameter int        CNT_W    = 8,
  localparam int       WORDS    = DEPTH * NUM_CH,
  localparam int       IW       = idx_width(WORDS),
  localparam int       CH_W     = idx_width(NUM_CH)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             sample_ready_i,
  input  logic [CH_W-1:0]  sample_ch_i,
  input  logic             rd_busy_i,
  input  logic             rd_final_ack_i,
  output logic             wr_en_o,
  output logic             wr_bank_o,
  output logic [IW-1:0]    wr_idx_o,
  output logic             swap_o,
  output logic             overrun_o,
  output logic [CNT_W-1:0] overrun_cnt_o,
  output logic             sync_err_o
);

  localparam logic [IW-1:0]   LAST_IDX = IW'(WORDS - 1);
  localparam logic [CH_W-1:0] LAST_CH  = CH_W'(NUM_CH - 1);

  logic             wr_bank_q,  wr_bank_d;
  logic [IW-1:0]    wr_idx_q,   wr_idx_d;
  logic [CH_W-1:0]  exp_ch_q,   exp_ch_d;
  logic             sync_err_q, sync_err_d;
  logic             ovr_q,      ovr_d;
  logic [CNT_W-1:0] ovr_cnt_q,  ovr_cnt_d;

  logic ch_ok;
  logic bank_full;
  logic reader_free;

  // NOTE: every variable driven here gets a default before any branch, so no
  // path leaves a value unassigned and no latch is inferred.
  always_comb begin
    wr_idx_d   = wr_idx_q;
    exp_ch_d   = exp_ch_q;
    wr_bank_d  = wr_bank_q;
    sync_err_d = sync_err_q;
    ovr_d      = 1'b0;
    ovr_cnt_d  = ovr_cnt_q;

    ch_ok       = (sample_ch_i == exp_ch_q);
    bank_full   = sample_ready_i && ch_ok && (wr_idx_q == LAST_IDX);
    // A reader acking its last word this cycle is as good as idle.
    reader_free = !rd_busy_i || rd_final_ack_i;

    wr_en_o = sample_ready_i && ch_ok;
    swap_o  = bank_full && (reader_free || (OVR_MODE == OVR_OVERWRITE));

    if (sample_ready_i) begin
      if (ch_ok) begin
        wr_idx_d = (wr_idx_q == LAST_IDX) ? '0 : wr_idx_q + IW'(1);
        exp_ch_d = (exp_ch_q == LAST_CH)  ? '0 : exp_ch_q + CH_W'(1);
      end else begin
        // exp_ch_q equals the number of words already stored for the
        // current frame, so subtracting it rewinds to the frame start.
        sync_err_d = 1'b1;
        wr_idx_d   = wr_idx_q - IW'(exp_ch_q);
        exp_ch_d   = '0;
      end
    end

    if (swap_o) begin
      wr_bank_d = ~wr_bank_q;
    end

    if (bank_full && !reader_free) begin
      ovr_d = 1'b1;
      if (ovr_cnt_q != '1) begin
        ovr_cnt_d = ovr_cnt_q + CNT_W'(1);
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of process ordering.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_bank_q  <= 1'b0;
      wr_idx_q   <= '0;
      exp_ch_q   <= '0;
      sync_err_q <= 1'b0;
      ovr_q      <= 1'b0;
      ovr_cnt_q  <= '0;
    end else begin
      wr_bank_q  <= wr_bank_d;
      wr_idx_q   <= wr_idx_d;
      exp_ch_q   <= exp_ch_d;
      sync_err_q <= sync_err_d;
      ovr_q      <= ovr_d;
      ovr_cnt_q  <= ovr_cnt_d;
    end
  end

  assign wr_bank_o     = wr_bank_q;
  assign wr_idx_o      = wr_idx_q;
  assign overrun_o     = ovr_q;
  assign overrun_cnt_o = ovr_cnt_q;
  assign sync_err_o    = sync_err_q;

endmodule : pingpong_mc_wr_ctrl

// File: rtl/pingpong_mc_ram.sv
// -----------------------------------------------------------------------------
// pingpong_mc_ram
// Two-bank ping-pong capture RAM for interleaved multi-channel samples. The
// writer fills one bank of DEPTH frames (NUM_CH words each) while a consumer
// drains the other with a ready/enable/ack handshake at up to 1 word/clk.
//
// Ports:
//   clk_i, rst_ni     clock, asynchronous active-low reset
//   sample_i          incoming sample
//   sample_ch_i       channel tag of sample_i
//   sample_ready_i    one-cycle strobe: sample_i is valid
//   read_data_o       current word of the read bank (0 while idle)
//   read_ch_o         channel of read_data_o
//   read_last_o       read_data_o is the final word of the bank
//   buffer_ready_o    one-cycle pulse: a new bank is available
//   read_enable_o     read bank has unread words
//   read_ack_i        consumer took read_data_o
//   overrun_o         one-cycle pulse per overrun
//   overrun_cnt_o     saturating overrun count
//   sync_err_o        sticky channel misalignment flag
// -----------------------------------------------------------------------------
module pingpong_mc_ram
  import pingpong_pkg::*;
#(
  parameter int  WIDTH    = 16,
  parameter int  DEPTH    = 256,
  parameter int  NUM_CH   = 2,
  parameter int  OVR_MODE = 0,
  parameter int  CNT_W    = 8,
  localparam int CH_W     = idx_width(NUM_CH)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] sample_i,
  input  logic [CH_W-1:0]  sample_ch_i,
  input  logic             sample_ready_i,
  output logic [WIDTH-1:0] read_data_o,
  output logic [CH_W-1:0]  read_ch_o,
  output logic             read_last_o,
  output logic             buffer_ready_o,
  output logic             read_enable_o,
  input  logic             read_ack_i,
  output logic             overrun_o,
  output logic [CNT_W-1:0] overrun_cnt_o,
  output logic             sync_err_o
);

  localparam int        WORDS      = DEPTH * NUM_CH;
  localparam int        IW         = idx_width(WORDS);
  localparam int        AW         = idx_width(2 * WORDS);
  localparam ovr_mode_e OVR_POLICY = (OVR_MODE != 0) ? OVR_OVERWRITE : OVR_DROP;

  localparam logic [IW-1:0]   LAST_IDX = IW'(WORDS - 1);
  localparam logic [CH_W-1:0] LAST_CH  = CH_W'(NUM_CH - 1);

  // Bank 0 occupies words [0, WORDS), bank 1 occupies [WORDS, 2*WORDS).
  function automatic logic [AW-1:0] word_addr(input logic bank, input logic [IW-1:0] idx);
    return AW'(idx) + (bank ? AW'(WORDS) : AW'(0));
  endfunction

  // ---------------------------------------------------------------------------
  // Write side
  // ---------------------------------------------------------------------------
  logic          wr_en;
  logic          wr_bank;
  logic [IW-1:0] wr_idx;
  logic          swap;

  logic          rd_active;
  logic          rd_last;
  logic          rd_take;
  logic          rd_final_ack;

  pingpong_mc_wr_ctrl #(
    .DEPTH    (DEPTH),
    .NUM_CH   (NUM_CH),
    .OVR_MODE (OVR_POLICY),
    .CNT_W    (CNT_W)
  ) u_wr_ctrl (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .sample_ready_i (sample_ready_i),
    .sample_ch_i    (sample_ch_i),
    .rd_busy_i      (rd_active),
    .rd_final_ack_i (rd_final_ack),
    .wr_en_o        (wr_en),
    .wr_bank_o      (wr_bank),
    .wr_idx_o       (wr_idx),
    .swap_o         (swap),
    .overrun_o      (overrun_o),
    .overrun_cnt_o  (overrun_cnt_o),
    .sync_err_o     (sync_err_o)
  );

  // ---------------------------------------------------------------------------
  // Read FSM
  // ---------------------------------------------------------------------------
  rd_state_e       rd_state_q, rd_state_d;
  logic            rd_bank_q,  rd_bank_d;
  logic [IW-1:0]   rd_idx_q,   rd_idx_d;
  logic [CH_W-1:0] rd_ch_q,    rd_ch_d;
  logic            buf_rdy_q,  buf_rdy_d;

  assign rd_active    = (rd_state_q == RD_ACTIVE);
  assign rd_last      = (rd_idx_q == LAST_IDX);
  assign rd_take      = rd_active && read_ack_i;
  assign rd_final_ack = rd_take && rd_last;

  always_comb begin
    rd_state_d = rd_state_q;
    rd_bank_d  = rd_bank_q;
    rd_idx_d   = rd_idx_q;
    rd_ch_d    = rd_ch_q;
    buf_rdy_d  = 1'b0;

    // A swap wins over a concurrent ack: either the ack was the final one
    // (reader would go idle anyway) or the overwrite policy restarts it.
    if (swap) begin
      rd_state_d = RD_ACTIVE;
      rd_bank_d  = wr_bank;
      rd_idx_d   = '0;
      rd_ch_d    = '0;
      buf_rdy_d  = 1'b1;
    end else if (rd_take) begin
      if (rd_last) begin
        rd_state_d = RD_IDLE;
        rd_idx_d   = '0;
        rd_ch_d    = '0;
      end else begin
        rd_idx_d = rd_idx_q + IW'(1);
        rd_ch_d  = (rd_ch_q == LAST_CH) ? '0 : rd_ch_q + CH_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_state_q <= RD_IDLE;
      rd_bank_q  <= 1'b0;
      rd_idx_q   <= '0;
      rd_ch_q    <= '0;
      buf_rdy_q  <= 1'b0;
    end else begin
      rd_state_q <= rd_state_d;
      rd_bank_q  <= rd_bank_d;
      rd_idx_q   <= rd_idx_d;
      rd_ch_q    <= rd_ch_d;
      buf_rdy_q  <= buf_rdy_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Sample RAM
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] mem [2*WORDS];
  logic [WIDTH-1:0] rd_data_q;

  // The read address is the next-state index, so the registered RAM output
  // already holds the word the reader will present in the following cycle.
  // The writer and reader always sit in different banks, except in the swap
  // cycle where the writer stores the last word and the reader fetches word 0.
  // NOTE: the array and its output register carry no reset; a reset would
  // prevent block-RAM inference, and the outputs are masked while idle.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      mem[word_addr(wr_bank, wr_idx)] <= sample_i;
    end
    rd_data_q <= mem[word_addr(rd_bank_d, rd_idx_d)];
  end

  assign read_enable_o  = rd_active;
  assign read_data_o    = rd_active ? rd_data_q : '0;
  assign read_ch_o      = rd_active ? rd_ch_q : '0;
  assign read_last_o    = rd_active && rd_last;
  assign buffer_ready_o = buf_rdy_q;

endmodule : pingpong_mc_ram

// File: tb/tb_pingpong_mc_ram.sv
// -----------------------------------------------------------------------------
// tb_pingpong_mc_ram
// Drives two instances (drop and overwrite overrun policy) with identical
// stimulus and compares every cycle against a bank-level reference model.
// -----------------------------------------------------------------------------
module tb_pingpong_mc_ram;

  localparam int W     = 16;
  localparam int D     = 4;
  localparam int N     = 2;
  localparam int CW    = 3;
  localparam int CHW   = 1;
  localparam int WORDS = D * N;
  localparam int CMAX  = (1 << CW) - 1;

  logic           clk = 1'b0;
  logic           rst_n = 1'b1;
  logic [W-1:0]   sample = '0;
  logic [CHW-1:0] sample_ch = '0;
  logic           sample_ready = 1'b0;
  logic           read_ack = 1'b0;

  logic [W-1:0]   rd_data  [2];
  logic [CHW-1:0] rd_ch    [2];
  logic           rd_last  [2];
  logic           buf_rdy  [2];
  logic           rd_en    [2];
  logic           ovr      [2];
  logic [CW-1:0]  ovr_cnt  [2];
  logic           sync_err [2];

  always #5 clk = ~clk;

  pingpong_mc_ram #(.WIDTH(W), .DEPTH(D), .NUM_CH(N), .OVR_MODE(0), .CNT_W(CW)) u_dut_drop (
    .clk_i(clk), .rst_ni(rst_n), .sample_i(sample), .sample_ch_i(sample_ch),
    .sample_ready_i(sample_ready), .read_data_o(rd_data[0]), .read_ch_o(rd_ch[0]),
    .read_last_o(rd_last[0]), .buffer_ready_o(buf_rdy[0]), .read_enable_o(rd_en[0]),
    .read_ack_i(read_ack), .overrun_o(ovr[0]), .overrun_cnt_o(ovr_cnt[0]),
    .sync_err_o(sync_err[0])
  );

  pingpong_mc_ram #(.WIDTH(W), .DEPTH(D), .NUM_CH(N), .OVR_MODE(1), .CNT_W(CW)) u_dut_ovwr (
    .clk_i(clk), .rst_ni(rst_n), .sample_i(sample), .sample_ch_i(sample_ch),
    .sample_ready_i(sample_ready), .read_data_o(rd_data[1]), .read_ch_o(rd_ch[1]),
    .read_last_o(rd_last[1]), .buffer_ready_o(buf_rdy[1]), .read_enable_o(rd_en[1]),
    .read_ack_i(read_ack), .overrun_o(ovr[1]), .overrun_cnt_o(ovr_cnt[1]),
    .sync_err_o(sync_err[1])
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
  endtask

  // ---------------------------------------------------------------------------
  // Reference model, one per policy: m = 0 drop, m = 1 overwrite.
  // The writer collects accepted samples in a bank buffer; a full buffer is
  // either copied to the reader or counted as an overrun.
  // ---------------------------------------------------------------------------
  int m_wr   [2][WORDS];
  int m_rd   [2][WORDS];
  int m_wr_n [2];
  int m_pos  [2];
  int m_cnt  [2];
  bit m_act  [2];
  bit m_br   [2];
  bit m_ovr  [2];
  bit m_sync [2];

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_wr_n[m] = 0; m_pos[m] = 0; m_cnt[m] = 0;
      m_act[m] = 0; m_br[m] = 0; m_ovr[m] = 0; m_sync[m] = 0;
    end
  endtask

  task automatic model_step(input int m);
    bit fin, busy;
    fin  = m_act[m] && read_ack && (m_pos[m] == WORDS - 1);
    busy = m_act[m] && !fin;
    m_br[m]  = 0;
    m_ovr[m] = 0;
    if (m_act[m] && read_ack) begin
      if (m_pos[m] == WORDS - 1) m_act[m] = 0;
      else m_pos[m]++;
    end
    if (sample_ready) begin
      if (int'(sample_ch) == m_wr_n[m] % N) begin
        m_wr[m][m_wr_n[m]] = int'(sample);
        m_wr_n[m]++;
        if (m_wr_n[m] == WORDS) begin
          m_wr_n[m] = 0;
          if (busy) begin
            m_ovr[m] = 1;
            if (m_cnt[m] < CMAX) m_cnt[m]++;
          end
          if (!busy || m == 1) begin
            for (int k = 0; k < WORDS; k++) m_rd[m][k] = m_wr[m][k];
            m_pos[m] = 0;
            m_act[m] = 1;
            m_br[m]  = 1;
          end
        end
      end else begin
        m_sync[m] = 1;
        m_wr_n[m] = m_wr_n[m] - (m_wr_n[m] % N);
      end
    end
  endtask

  task automatic compare(input int m);
    check($sformatf("m%0d read_enable", m), rd_en[m], m_act[m]);
    check($sformatf("m%0d buffer_ready", m), buf_rdy[m], m_br[m]);
    check($sformatf("m%0d overrun", m), ovr[m], m_ovr[m]);
    check($sformatf("m%0d overrun_cnt", m), ovr_cnt[m], m_cnt[m]);
    check($sformatf("m%0d sync_err", m), sync_err[m], m_sync[m]);
    if (m_act[m]) begin
      check($sformatf("m%0d read_data[%0d]", m, m_pos[m]), rd_data[m], m_rd[m][m_pos[m]]);
      check($sformatf("m%0d read_ch[%0d]", m, m_pos[m]), rd_ch[m], m_pos[m] % N);
      check($sformatf("m%0d read_last[%0d]", m, m_pos[m]), rd_last[m], m_pos[m] == WORDS - 1);
    end
  endtask

  task automatic cycle(input bit rdy, input int ch, input int data, input bit ack);
    sample_ready = rdy;
    sample_ch    = CHW'(ch);
    sample       = W'(data);
    read_ack     = ack;
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
    compare(0);
    compare(1);
  endtask

  task automatic idle(input int n, input bit ack);
    for (int i = 0; i < n; i++) cycle(1'b0, 0, 0, ack);
  endtask

  task automatic write_bank(input int base, input bit ack);
    for (int i = 0; i < WORDS; i++) cycle(1'b1, i % N, base + i, ack);
  endtask

  // Asserts reset between edges and checks the outputs clear immediately.
  task automatic do_reset();
    sample_ready = 1'b0;
    read_ack     = 1'b0;
    rst_n        = 1'b0;
    #1;
    for (int m = 0; m < 2; m++) begin
      check($sformatf("m%0d rst read_enable", m), rd_en[m], 0);
      check($sformatf("m%0d rst buffer_ready", m), buf_rdy[m], 0);
      check($sformatf("m%0d rst overrun", m), ovr[m], 0);
      check($sformatf("m%0d rst overrun_cnt", m), ovr_cnt[m], 0);
      check($sformatf("m%0d rst sync_err", m), sync_err[m], 0);
      check($sformatf("m%0d rst read_data", m), rd_data[m], 0);
      check($sformatf("m%0d rst read_ch", m), rd_ch[m], 0);
      check($sformatf("m%0d rst read_last", m), rd_last[m], 0);
    end
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int c;
    #2;
    do_reset();
    idle(2, 1'b1);

    // Basic fill and full-rate drain.
    write_bank(16'h1000, 1'b0);
    idle(10, 1'b1);

    // Consumer stalls three cycles between acks.
    write_bank(16'h1100, 1'b0);
    for (int i = 0; i < WORDS; i++) begin
      idle(3, 1'b0);
      idle(1, 1'b1);
    end
    idle(2, 1'b0);

    // Overrun: reader parked at word 3 while the next bank completes.
    write_bank(16'h1200, 1'b0);
    idle(3, 1'b1);
    write_bank(16'h2000, 1'b0);
    idle(20, 1'b1);

    // Final write and final ack in the same cycle.
    write_bank(16'h3000, 1'b0);
    for (int i = 0; i < WORDS - 1; i++) cycle(1'b1, i % N, 16'h3100 + i, 1'b1);
    cycle(1'b1, (WORDS - 1) % N, 16'h3100 + WORDS - 1, 1'b1);
    idle(12, 1'b1);

    // Channel 0 twice: misalignment, frame restarts.
    cycle(1'b1, 0, 16'h4000, 1'b0);
    cycle(1'b1, 0, 16'h4001, 1'b0);
    write_bank(16'h4100, 1'b0);
    idle(12, 1'b1);

    // Random traffic with occasional misaligned tags.
    for (int i = 0; i < 600; i++) begin
      c = m_wr_n[0] % N;
      if ($urandom_range(0, 19) == 0) c = (c + 1 + $urandom_range(0, N - 2)) % N;
      cycle($urandom_range(0, 1) == 1, c, $urandom_range(0, 16'hffff),
            $urandom_range(0, 9) < 6);
    end

    // Slow consumer, full-rate writer: repeated overruns, counter saturates.
    for (int i = 0; i < 300; i++) begin
      cycle(1'b1, m_wr_n[0] % N, $urandom_range(0, 16'hffff), $urandom_range(0, 9) == 0);
    end
    idle(20, 1'b1);

    // Reset in the middle of a read, then a clean bank.
    do_reset();
    write_bank(16'h5000, 1'b0);
    idle(5, 1'b1);
    do_reset();
    write_bank(16'h6000, 1'b0);
    idle(12, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_pingpong_mc_ram
